// File: rtl/rsa_dispatch_pkg.sv
// Shared definitions for the RSA command dispatcher: command field layout,
// opcodes, status codes and FSM state encoding.
package rsa_dispatch_pkg;

    // Command word field positions
    localparam int OPC_LSB = 0;
    localparam int IDX_LSB = 8;

    // Opcodes
    localparam logic [3:0] OP_LOAD       = 4'd0;
    localparam logic [3:0] OP_START_MULT = 4'd1;
    localparam logic [3:0] OP_START_EXP  = 4'd2;
    localparam logic [3:0] OP_WAIT       = 4'd3;
    localparam logic [3:0] OP_WRITE      = 4'd4;
    localparam logic [3:0] OP_STATUS     = 4'd5;

    // Status codes returned in port2_dout[3:0]
    localparam logic [3:0] ST_OK         = 4'd0;
    localparam logic [3:0] ST_BAD_OPCODE = 4'd1;
    localparam logic [3:0] ST_BAD_INDEX  = 4'd2;
    localparam logic [3:0] ST_CORE_BUSY  = 4'd3;
    localparam logic [3:0] ST_NO_RESULT  = 4'd4;

    // FSM states; the encoding is visible on leds[2:0]
    typedef enum logic [2:0] {
        S_WAIT_CMD  = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_WRITE     = 3'd4,
        S_RESP      = 3'd5
    } state_e;

    // Opcodes whose idx field addresses a core rather than an operand slot
    function automatic logic is_core_op(input logic [3:0] op);
        return (op == OP_START_MULT) || (op == OP_START_EXP) ||
               (op == OP_WAIT) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/rsa_cmd_dispatcher_core_tracker.sv
// Per-core bookkeeping: busy, result-valid and mode flags. A done pulse frees
// a busy core and marks its result valid in any dispatcher state; a start in
// the same cycle as a done on the same core wins (core busy, result invalid).
module dispatch_core_tracker #(
    parameter int NUM_CORES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] start_vec,
    input  logic                 start_exp,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] busy_eff,
    output logic [NUM_CORES-1:0] busy_next,
    output logic [NUM_CORES-1:0] res_valid,
    output logic [NUM_CORES-1:0] res_valid_next,
    output logic [NUM_CORES-1:0] core_mode
);
    logic [NUM_CORES-1:0] busy_reg;
    logic [NUM_CORES-1:0] res_valid_reg;
    logic [NUM_CORES-1:0] mode_reg;
    logic [NUM_CORES-1:0] mode_next;

    // Next-state of the per-core flags; done only counts for a busy core
    always_comb begin
        busy_eff       = busy_reg & ~core_done;
        busy_next      = busy_eff | start_vec;
        res_valid_next = (res_valid_reg | (core_done & busy_reg)) & ~start_vec;
        mode_next      = (mode_reg & ~start_vec) | (start_vec & {NUM_CORES{start_exp}});
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg      <= '0;
            res_valid_reg <= '0;
            mode_reg      <= '0;
        end else begin
            busy_reg      <= busy_next;
            res_valid_reg <= res_valid_next;
            mode_reg      <= mode_next;
        end
    end

    // Mode is presented already during the start pulse and held afterwards
    assign res_valid = res_valid_reg;
    assign core_mode = mode_next;

endmodule

// File: rtl/rsa_cmd_dispatcher.sv
// Command front-end for the RSA accelerator: decodes ARM commands, loads
// operand slots from BRAM, launches Montgomery jobs without blocking, writes
// core results back to BRAM and reports a status word per command.
module rsa_cmd_dispatcher
    import rsa_dispatch_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int N_OPS     = 5,
    parameter int NUM_CORES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 port1_din,
    input  logic                        port1_valid,
    output logic                        port1_read,
    output logic [31:0]                 port2_dout,
    output logic                        port2_valid,
    input  logic                        port2_read,
    input  logic [DATA_W-1:0]           bram_din,
    input  logic                        bram_din_valid,
    output logic [DATA_W-1:0]           bram_dout,
    output logic                        bram_dout_valid,
    input  logic                        bram_dout_read,
    output logic [N_OPS*DATA_W-1:0]     ops_flat,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [NUM_CORES-1:0]        core_mode,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES*DATA_W-1:0] core_result,
    output logic [3:0]                  leds
);
    localparam logic [4:0] N_OPS_L   = 5'(N_OPS);
    localparam logic [4:0] N_CORES_L = 5'(NUM_CORES);

    state_e               state_reg, state_next;
    logic [3:0]           op_reg, idx_reg;
    logic [3:0]           cmd_op, cmd_idx;
    logic                 port1_read_reg, sticky_reg, dout_valid_reg;
    logic [31:0]          status_reg;
    logic [DATA_W-1:0]    slot_reg [N_OPS];
    logic [DATA_W-1:0]    bram_dout_reg, result_sel;
    logic                 resp_load, start_fire, write_load;
    logic [3:0]           code_next;
    logic [NUM_CORES-1:0] start_vec, busy_eff, busy_next, res_valid, res_valid_next;
    logic [15:0]          busy_eff_w, res_valid_w;
    logic                 unused_cmd_bits;

    assign cmd_op          = port1_din[OPC_LSB +: 4];
    assign cmd_idx         = port1_din[IDX_LSB +: 4];
    assign unused_cmd_bits = ^{port1_din[31:12], port1_din[7:4]};
    // Widened to 16 so any 4-bit index selects a defined (zero) bit
    assign busy_eff_w      = 16'(busy_eff);
    assign res_valid_w     = 16'(res_valid);

    dispatch_core_tracker #(.NUM_CORES(NUM_CORES)) u_tracker (
        .clk            (clk),
        .reset          (reset),
        .start_vec      (start_vec),
        .start_exp      (op_reg == OP_START_EXP),
        .core_done      (core_done),
        .busy_eff       (busy_eff),
        .busy_next      (busy_next),
        .res_valid      (res_valid),
        .res_valid_next (res_valid_next),
        .core_mode      (core_mode)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_WAIT_CMD;
        else       state_reg <= state_next;
    end

    // Next-state logic with command validation and per-state decisions
    always_comb begin
        state_next = state_reg;
        code_next  = ST_OK;
        start_fire = 1'b0;
        write_load = 1'b0;
        unique case (state_reg)
            S_WAIT_CMD: if (port1_valid) begin
                if (cmd_op > OP_STATUS) begin
                    code_next  = ST_BAD_OPCODE;
                    state_next = S_RESP;
                end else if ((cmd_op == OP_LOAD && {1'b0, cmd_idx} >= N_OPS_L) ||
                             (is_core_op(cmd_op) && {1'b0, cmd_idx} >= N_CORES_L)) begin
                    code_next  = ST_BAD_INDEX;
                    state_next = S_RESP;
                end else begin
                    case (cmd_op)
                        OP_LOAD:                     state_next = S_LOAD;
                        OP_START_MULT, OP_START_EXP: state_next = S_START;
                        OP_WAIT:                     state_next = S_WAIT_CORE;
                        OP_WRITE:                    state_next = S_WRITE;
                        default:                     state_next = S_RESP;
                    endcase
                end
            end
            S_LOAD: if (bram_din_valid) state_next = S_RESP;
            S_START: begin
                state_next = S_RESP;
                if (busy_eff_w[idx_reg]) code_next  = ST_CORE_BUSY;
                else                     start_fire = 1'b1;
            end
            S_WAIT_CORE: if (!busy_eff_w[idx_reg]) state_next = S_RESP;
            S_WRITE: begin
                if (!dout_valid_reg) begin
                    if (res_valid_w[idx_reg]) begin
                        write_load = 1'b1;
                    end else begin
                        code_next  = ST_NO_RESULT;
                        state_next = S_RESP;
                    end
                end else if (bram_dout_read) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: if (port2_read) state_next = S_WAIT_CMD;
            default: state_next = S_WAIT_CMD;
        endcase
        resp_load = (state_next == S_RESP) && (state_reg != S_RESP);
    end

    // Output logic
    always_comb begin
        port1_read      = port1_read_reg;
        port2_valid     = (state_reg == S_RESP);
        port2_dout      = status_reg;
        bram_dout       = bram_dout_reg;
        bram_dout_valid = dout_valid_reg;
        core_start      = start_vec;
        leds            = {sticky_reg, state_reg};
    end

    // Command latch, status snapshot (flags after this cycle's update) and write-back register
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg         <= '0;
            idx_reg        <= '0;
            port1_read_reg <= 1'b0;
            status_reg     <= '0;
            sticky_reg     <= 1'b0;
            bram_dout_reg  <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            port1_read_reg <= (state_reg == S_WAIT_CMD) && port1_valid;
            if (state_reg == S_WAIT_CMD && port1_valid) begin
                op_reg  <= cmd_op;
                idx_reg <= cmd_idx;
            end
            if (resp_load) begin
                status_reg <= {8'(res_valid_next), 8'(busy_next), 12'd0, code_next};
                if (code_next != ST_OK) sticky_reg <= 1'b1;
            end
            if (write_load) begin
                bram_dout_reg  <= result_sel;
                dout_valid_reg <= 1'b1;
            end else if (state_reg == S_WRITE && dout_valid_reg && bram_dout_read) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    // Result mux for the addressed core
    always_comb begin
        result_sel = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (idx_reg == 4'(c)) result_sel = core_result[c*DATA_W +: DATA_W];
        end
    end

    // Operand slots, each loaded only when LOAD addresses it
    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset)
                slot_reg[gi] <= '0;
            else if (state_reg == S_LOAD && bram_din_valid && idx_reg == 4'(gi))
                slot_reg[gi] <= bram_din;
        end
        assign ops_flat[gi*DATA_W +: DATA_W] = slot_reg[gi];
    end

    // Start pulse decode, one bit per core
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_start
        assign start_vec[gi] = start_fire && (idx_reg == 4'(gi));
    end

endmodule
